// File: rtl/bsg_axil_arbiter.sv
// Round-robin arbiter that multiplexes num_p AXI-Lite requesters onto one shared
// master port, with exactly one transaction (write or read) in flight at a time.
module bsg_axil_arbiter #(
    parameter int num_p        = 2,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,

    // Requester side, slot i belongs to requester i
    input  logic [num_p-1:0][addr_width_p-1:0]       s_awaddr_i,
    input  logic [num_p-1:0][2:0]                    s_awprot_i,
    input  logic [num_p-1:0]                         s_awvalid_i,
    output logic [num_p-1:0]                         s_awready_o,
    input  logic [num_p-1:0][data_width_p-1:0]       s_wdata_i,
    input  logic [num_p-1:0][data_width_p/8-1:0]     s_wstrb_i,
    input  logic [num_p-1:0]                         s_wvalid_i,
    output logic [num_p-1:0]                         s_wready_o,
    output logic [num_p-1:0][1:0]                    s_bresp_o,
    output logic [num_p-1:0]                         s_bvalid_o,
    input  logic [num_p-1:0]                         s_bready_i,
    input  logic [num_p-1:0][addr_width_p-1:0]       s_araddr_i,
    input  logic [num_p-1:0][2:0]                    s_arprot_i,
    input  logic [num_p-1:0]                         s_arvalid_i,
    output logic [num_p-1:0]                         s_arready_o,
    output logic [num_p-1:0][data_width_p-1:0]       s_rdata_o,
    output logic [num_p-1:0][1:0]                    s_rresp_o,
    output logic [num_p-1:0]                         s_rvalid_o,
    input  logic [num_p-1:0]                         s_rready_i,

    // Shared master side
    output logic [addr_width_p-1:0]                  m_awaddr_o,
    output logic [2:0]                               m_awprot_o,
    output logic                                     m_awvalid_o,
    input  logic                                     m_awready_i,
    output logic [data_width_p-1:0]                  m_wdata_o,
    output logic [data_width_p/8-1:0]                m_wstrb_o,
    output logic                                     m_wvalid_o,
    input  logic                                     m_wready_i,
    input  logic [1:0]                               m_bresp_i,
    input  logic                                     m_bvalid_i,
    output logic                                     m_bready_o,
    output logic [addr_width_p-1:0]                  m_araddr_o,
    output logic [2:0]                               m_arprot_o,
    output logic                                     m_arvalid_o,
    input  logic                                     m_arready_i,
    input  logic [data_width_p-1:0]                  m_rdata_i,
    input  logic [1:0]                               m_rresp_i,
    input  logic                                     m_rvalid_i,
    output logic                                     m_rready_o
);

    localparam int idx_width_lp = $clog2(num_p);

    typedef logic [idx_width_lp-1:0] idx_t;

    typedef enum logic [2:0] {
        eIdle,
        eWrite,
        eWResp,
        eRead,
        eRResp
    } state_e;

    state_e           state_q;
    idx_t             grant_q;
    idx_t             last_grant_q;
    logic             aw_done_q;
    logic             w_done_q;
    logic             aw_done_d;
    logic             w_done_d;

    logic [num_p-1:0] req;
    logic             win_found;
    idx_t             win_idx;
    logic             win_write;
    logic             ar_hs;
    logic             b_hs;
    logic             r_hs;

    assign req = (s_awvalid_i & s_wvalid_i) | s_arvalid_i;

    // Search upward from the slot after the last winner, wrapping modulo num_p.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant_q;
        for (int k = 1; k <= num_p; k++) begin
            if (!win_found && req[idx_t'((int'(last_grant_q) + k) % num_p)]) begin
                win_found = 1'b1;
                win_idx   = idx_t'((int'(last_grant_q) + k) % num_p);
            end
        end
    end

    assign win_write = s_awvalid_i[win_idx] & s_wvalid_i[win_idx];

    assign aw_done_d = aw_done_q | (m_awvalid_o & m_awready_i);
    assign w_done_d  = w_done_q  | (m_wvalid_o  & m_wready_i);
    assign ar_hs     = m_arvalid_o & m_arready_i;
    assign b_hs      = m_bvalid_i  & m_bready_o;
    assign r_hs      = m_rvalid_i  & m_rready_o;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= eIdle;
            grant_q      <= '0;
            last_grant_q <= idx_t'(num_p - 1);
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                eIdle: begin
                    if (win_found) begin
                        grant_q   <= win_idx;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= win_write ? eWrite : eRead;
                    end
                end
                eWrite: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        state_q <= eWResp;
                    end
                end
                eWResp: begin
                    if (b_hs) begin
                        state_q      <= eIdle;
                        last_grant_q <= grant_q;
                        aw_done_q    <= 1'b0;
                        w_done_q     <= 1'b0;
                    end
                end
                eRead: begin
                    if (ar_hs) begin
                        state_q <= eRResp;
                    end
                end
                eRResp: begin
                    if (r_hs) begin
                        state_q      <= eIdle;
                        last_grant_q <= grant_q;
                    end
                end
                default: state_q <= eIdle;
            endcase
        end
    end

    // Forwarding is gated by reset so an abandoned response never reaches a requester.
    always_comb begin
        s_awready_o = '0;
        s_wready_o  = '0;
        s_bresp_o   = '0;
        s_bvalid_o  = '0;
        s_arready_o = '0;
        s_rdata_o   = '0;
        s_rresp_o   = '0;
        s_rvalid_o  = '0;
        m_awaddr_o  = '0;
        m_awprot_o  = '0;
        m_awvalid_o = 1'b0;
        m_wdata_o   = '0;
        m_wstrb_o   = '0;
        m_wvalid_o  = 1'b0;
        m_bready_o  = 1'b0;
        m_araddr_o  = '0;
        m_arprot_o  = '0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        if (!reset_i) begin
            unique case (state_q)
                eWrite: begin
                    m_awaddr_o           = s_awaddr_i[grant_q];
                    m_awprot_o           = s_awprot_i[grant_q];
                    m_awvalid_o          = !aw_done_q;
                    m_wdata_o            = s_wdata_i[grant_q];
                    m_wstrb_o            = s_wstrb_i[grant_q];
                    m_wvalid_o           = !w_done_q;
                    s_awready_o[grant_q] = m_awready_i & !aw_done_q;
                    s_wready_o[grant_q]  = m_wready_i & !w_done_q;
                end
                eWResp: begin
                    s_bvalid_o[grant_q] = m_bvalid_i;
                    s_bresp_o[grant_q]  = m_bresp_i;
                    m_bready_o          = s_bready_i[grant_q];
                end
                eRead: begin
                    m_araddr_o           = s_araddr_i[grant_q];
                    m_arprot_o           = s_arprot_i[grant_q];
                    m_arvalid_o          = 1'b1;
                    s_arready_o[grant_q] = m_arready_i;
                end
                eRResp: begin
                    s_rvalid_o[grant_q] = m_rvalid_i;
                    s_rdata_o[grant_q]  = m_rdata_i;
                    s_rresp_o[grant_q]  = m_rresp_i;
                    m_rready_o          = s_rready_i[grant_q];
                end
                default: ;
            endcase
        end
    end

endmodule
